// File: rtl/west_skew_feeder.sv
// West-edge feeder for the systolic MAC array: buffers activation vectors in a
// small FIFO and issues them diagonally skewed (row r delayed r cycles).

module west_skew_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);
  logic [DEPTH-1:0][W-1:0] data_q;
  logic [DEPTH-1:0]        vld_pipe_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      data_q[0]     <= d_i;
      vld_pipe_q[0] <= v_i;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]     <= data_q[k-1];
        vld_pipe_q[k] <= vld_pipe_q[k-1];
      end
    end
  end

  assign d_o = data_q[DEPTH-1];
  assign v_o = vld_pipe_q[DEPTH-1];
endmodule

module west_skew_feeder #(
  parameter int DATA_SIZE  = 8,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROWS*DATA_SIZE-1:0]     vec_in,
  input  logic                          vec_valid,
  input  logic                          vec_last,
  output logic                          vec_ready,
  output logic [ROWS*2*DATA_SIZE-1:0]   west_out,
  output logic [ROWS-1:0]               west_valid,
  output logic [31:0]                   mac_matrix_counter,
  output logic                          busy,
  output logic                          done
);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int DCW        = $clog2(ROWS + 1);
  localparam int DRAIN_LAST = (ROWS > 1) ? ROWS - 2 : 0;

  typedef logic [AW:0] ptr_t;
  typedef struct packed {
    logic                                last;
    logic [ROWS-1:0][DATA_SIZE-1:0]      vec;
  } fifo_ent_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  fifo_ent_t mem_q [FIFO_DEPTH];
  ptr_t      wr_ptr_q, rd_ptr_q;
  fifo_ent_t head;
  logic      full, empty, push, pop;

  state_t          state_q, state_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [ROWS-1:0][DATA_SIZE-1:0] iss_vec, lane_d;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign vec_ready = !full;
  assign push      = vec_valid && !full;
  assign pop       = (state_q == STREAM) && !empty;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{last: vec_last, vec: vec_in};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    cnt_d   = (state_q != IDLE) ? cnt_q + 32'd1 : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: if (pop && head.last) begin
        if (ROWS == 1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: if (drain_q == DCW'(DRAIN_LAST)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        drain_d = drain_q + DCW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign mac_matrix_counter = cnt_q;

  // Non-pop cycles inject zero bubbles that ride the skew like real data.
  assign iss_vec = pop ? head.vec : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    west_skew_lane #(.W(DATA_SIZE), .DEPTH(r + 1)) u_lane (
      .clock (clock),
      .reset (reset),
      .d_i   (iss_vec[r]),
      .v_i   (pop),
      .d_o   (lane_d[r]),
      .v_o   (west_valid[r])
    );
    assign west_out[r*2*DATA_SIZE +: 2*DATA_SIZE] = {{DATA_SIZE{1'b0}}, lane_d[r]};
  end
endmodule

// File: tb/tb_west_skew_feeder.sv
// Scoreboard bench for west_skew_feeder: a cycle-level queue model predicts
// per-row outputs, done/busy/counter and ready; a negedge monitor compares.

module tb_west_skew_feeder;
  localparam int DS = 8, ROWS = 4, DEPTH = 8, W2 = 2 * DS;

  logic                 clock = 0, reset = 1, start = 0, vec_valid = 0, vec_last = 0;
  logic [ROWS*DS-1:0]   vec_in = '0;
  logic                 vec_ready, busy, done;
  logic [ROWS*W2-1:0]   west_out;
  logic [ROWS-1:0]      west_valid;
  logic [31:0]          mac_matrix_counter;

  west_skew_feeder #(.DATA_SIZE(DS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .vec_in(vec_in),
    .vec_valid(vec_valid), .vec_last(vec_last), .vec_ready(vec_ready),
    .west_out(west_out), .west_valid(west_valid),
    .mac_matrix_counter(mac_matrix_counter), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic last; logic [ROWS*DS-1:0] bits; } vec_t;
  typedef struct { logic [DS-1:0] d; int due; } exp_t;

  vec_t        mfifo[$];
  exp_t        exp_row[ROWS][$];
  bit          streaming = 0;
  int          end_edge = -1;
  logic [31:0] mcnt = '0;
  int          ecnt = 0;
  bit          mon_en = 0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic model_clear();
    mfifo.delete();
    for (int r = 0; r < ROWS; r++) exp_row[r].delete();
    streaming = 0;
    end_edge  = -1;
    mcnt      = '0;
  endtask

  // One clock: predict from pre-edge inputs/model, clock, update model.
  task automatic step();
    bit   acc, pp, busy_m;
    vec_t v;
    busy_m = streaming || (end_edge > ecnt);
    acc    = reset && vec_valid && (mfifo.size() < DEPTH);
    pp     = reset && streaming && (mfifo.size() > 0);
    @(posedge clock);
    ecnt++;
    if (reset) begin
      if (pp) begin
        v = mfifo.pop_front();
        for (int r = 0; r < ROWS; r++) exp_row[r].push_back('{v.bits[r*DS +: DS], ecnt + r});
        if (v.last) begin
          streaming = 0;
          end_edge  = ecnt + ROWS - 1;
        end
      end
      if (acc) mfifo.push_back('{vec_last, vec_in});
      if (!busy_m && start) begin
        streaming = 1;
        mcnt      = '0;
      end else if (busy_m) mcnt++;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push1(logic [ROWS*DS-1:0] v, bit last);
    vec_in = v; vec_last = last; vec_valid = 1;
    step();
    vec_valid = 0; vec_last = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  function automatic logic [ROWS*DS-1:0] pk(int a, int b, int c, int d);
    logic [DS-1:0] ea, eb, ec, ed;
    ea = a[DS-1:0]; eb = b[DS-1:0]; ec = c[DS-1:0]; ed = d[DS-1:0];
    return {ed, ec, eb, ea};
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      for (int r = 0; r < ROWS; r++) begin
        bit            has;
        logic [DS-1:0] d;
        has = (exp_row[r].size() > 0) && (exp_row[r][0].due == ecnt);
        d   = has ? exp_row[r][0].d : '0;
        chk($sformatf("row%0d_valid", r), 64'(west_valid[r]), 64'(has));
        chk($sformatf("row%0d_data", r), 64'(west_out[r*W2 +: W2]), 64'({{DS{1'b0}}, d}));
        if (has) void'(exp_row[r].pop_front());
      end
      chk("busy", 64'(busy), 64'(streaming || (end_edge > ecnt)));
      chk("done", 64'(done), 64'(end_edge == ecnt));
      chk("counter", 64'(mac_matrix_counter), 64'(mcnt));
      chk("vec_ready", 64'(vec_ready), 64'(mfifo.size() < DEPTH));
    end
  end

  initial begin
    #2 reset = 0;
    model_clear();
    mon_en = 1;
    steps(3);
    reset = 1;
    steps(2);

    // Two-vector pass buffered before start
    push1(pk(1, 2, 3, 4), 0);
    push1(pk(5, 6, 7, 8), 1);
    pulse_start();
    steps(10);

    // Fill FIFO without start; 9th offer must be refused
    for (int i = 0; i < DEPTH; i++) push1(32'($urandom), i == DEPTH - 1);
    push1(pk(9, 9, 9, 9), 0);
    pulse_start();
    steps(14);

    // Start empty, trickle one vector every other cycle
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      push1(32'($urandom), i == 3);
      step();
    end
    steps(8);

    // Async reset mid-stream with vectors buffered
    push1(pk(11, 12, 13, 14), 0);
    push1(pk(21, 22, 23, 24), 0);
    push1(pk(31, 32, 33, 34), 0);
    pulse_start();
    steps(2);
    reset = 0;
    #1;
    chk("async_rst_west_out", 64'(west_out), 64'(0));
    chk("async_rst_west_valid", 64'(west_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    model_clear();
    steps(2);
    reset = 1;
    steps(6);

    // Start during drain is ignored; 0xFF zero-extension; restart from 0
    push1(pk(255, 255, 255, 255), 0);
    push1(pk(1, 255, 2, 255), 1);
    pulse_start();
    steps(3);
    pulse_start();
    steps(6);
    push1(pk(7, 7, 7, 7), 1);
    pulse_start();
    steps(8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      vec_in    = 32'($urandom);
      vec_valid = 1'($urandom_range(0, 1));
      vec_last  = ($urandom_range(0, 3) == 0);
      start     = ($urandom_range(0, 7) == 0);
      step();
    end
    vec_valid = 0; start = 0; vec_last = 0;
    steps(12);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/west_skew_feeder.md
Name: west_skew_feeder

Overview:
- Edge stage directly upstream of the systolic MAC array; drives the array's west-edge data inputs, one per array row.
- Accepts whole activation vectors (one element per row) over a valid/ready handshake and buffers them in a small FIFO.
- Emits them diagonally skewed: row r is delayed r cycles, so operands meet the partial sums flowing south at the correct MAC.
- Also generates the array's shared matrix cycle counter.

Parameters:
- DATA_SIZE, 8: activation element width in bits.
- ROWS, 4: number of array rows fed, and number of elements per vector.
- FIFO_DEPTH, 8: vector buffer depth; power of two, minimum 2.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a matrix pass; honoured only in IDLE.
- vec_in  in  ROWS*DATA_SIZE  activation vector; element r in bits [r*DATA_SIZE +: DATA_SIZE].
- vec_valid  in  1  vec_in is valid.
- vec_last  in  1  qualifies the final vector of the matrix; sampled with the handshake.
- vec_ready  out  1  FIFO can accept a vector.
- west_out  out  ROWS*2*DATA_SIZE  per-row west data, zero-extended to 2*DATA_SIZE; row r in bits [r*2*DATA_SIZE +: 2*DATA_SIZE].
- west_valid  out  ROWS  per-row valid, skewed identically to the data.
- mac_matrix_counter  out  32  cycles elapsed since the accepted start.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at the end of the drain.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, all skew registers and west_out zero, west_valid=0, mac_matrix_counter=0, busy=0, done=0, state IDLE.
- Push: a vector and its last flag are written when vec_valid && vec_ready.
  - vec_ready = !fifo_full, independent of state; buffering before start is allowed.
  - No push-to-pop bypass. A vector pushed into an empty FIFO is poppable at the earliest on the following cycle.
- States:
  - IDLE: start -> STREAM; mac_matrix_counter cleared to 0 on that edge.
  - STREAM: each cycle, if the FIFO is non-empty, pop one vector into the issue stage with valid=1. Otherwise issue zeros with valid=0 (a bubble).
  - STREAM -> DRAIN: on the edge that pops a vector whose last flag=1.
  - DRAIN: issue zeros with valid=0 for exactly ROWS-1 cycles (drain counter), then -> IDLE with done=1 for one cycle.
- Skew:
  - Row 0 output register loads on the pop edge, so latency is 1 cycle from pop.
  - Row r passes through r additional registers, so it appears r cycles after row 0.
  - Bubbles propagate through the skew like data.
- mac_matrix_counter increments by 1 every cycle while busy and holds its value in IDLE. Wraps 0xFFFFFFFF -> 0.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- Simultaneous push and pop:
  - When neither full nor empty, both occur and the count is unchanged.
  - When full, only the pop occurs (ready was low).
- start while busy is ignored.
- vec_last on a vector pushed while in IDLE is retained in the FIFO and acted on when popped.
- Mid-operation reset: immediate return to the reset state; buffered vectors are discarded and no done pulse is generated.
- No arithmetic beyond zero-extension; elements are unsigned.

Test Plan:
- Reset release, ROWS=4, then push vectors {1,2,3,4} then {5,6,7,8, last} and pulse start -> row0 west_out shows 1 then 5 on consecutive cycles starting 1 cycle after the first pop; row3 shows 4 then 8 starting 3 cycles after row0; done pulses 3 cycles after the last pop; mac_matrix_counter=0 at entry to STREAM.
- Push 8 vectors without start (FIFO_DEPTH=8) -> vec_ready falls after the 8th accept; a 9th vec_valid is not accepted; start then yields 8 consecutive valid issues on row 0.
- Start with an empty FIFO, then push one vector every other cycle -> row0 west_valid alternates 1,0,1,0 and the bubble data is 0; the same pattern appears on row 3 delayed 3 cycles.
- Drive reset=0 mid-STREAM with 3 vectors buffered -> outputs zero immediately (asynchronous); after release, busy=0, vec_ready=1, and no done pulse.
- Pulse start again during DRAIN -> ignored; exactly one done pulse; a subsequent start in IDLE begins a new pass with the counter restarting at 0.
- Element value 0xFF -> row west_out = 0x00FF, confirming zero-extension.
